// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding and frame timing helper.
package uart_pkg;

  typedef enum logic [1:0] {INIT, IDLE, START, WAIT} TxSchedState;

  // Clocks from the start pulse to the end of the guard window.
  // The transmitter adds 2 cycles of latency ahead of its 10 bit slots.
  function automatic int frame_cycles(int clock_frequency, int baud_rate, int guard);
    return 10 * (clock_frequency / baud_rate) + 2 + guard;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Rotate-priority arbiter: searches from pointer+1 (mod NUM_REQ) for the first valid.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  // Walk the requesters in rotated order and latch onto the first valid one.
  always_comb begin
    logic    found;
    int      s;
    logic [IW-1:0] k;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    s         = 0;
    k         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      s = int'(pointer) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      k = IW'(s);
      if (!found && valid[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_transmitter among NUM_REQ byte sources. The transmitter gives
// no completion indication, so each frame is timed here and the byte is held
// on o_tx_data for the whole frame.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int CLOCK_FREQUENCY = 250000000,
  parameter int BAUD_RATE       = 10000,
  parameter int GUARD_CYCLES    = 2,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_tx_reset,
  output logic                 o_busy,
  output logic [IW-1:0]        o_grant_id
);

  localparam int CYCLES_PER_SAMPLE = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int FRAME_CYCLES      = frame_cycles(CLOCK_FREQUENCY, BAUD_RATE, GUARD_CYCLES);
  localparam int CW                = $clog2(FRAME_CYCLES + 1);

  TxSchedState          state;
  logic                 init_cnt;
  logic [IW-1:0]        ptr;
  logic [CW-1:0]        wait_cnt;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [7:0]           sel_data;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid     (i_req_valid),
    .pointer   (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign arb_any     = |arb_grant;
  assign sel_data    = i_req_data[8*arb_idx +: 8];
  assign o_req_ready = (state == IDLE) ? arb_grant : '0;
  assign o_busy      = (state != IDLE);

  // Scheduler FSM: hold transmitter in reset, accept one byte, pulse start,
  // then wait out the frame plus guard before accepting again.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= INIT;
      init_cnt   <= 1'b0;
      ptr        <= IW'(NUM_REQ - 1);
      wait_cnt   <= '0;
      o_tx_reset <= 1'b1;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_grant_id <= '0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt) begin
            state      <= IDLE;
            o_tx_reset <= 1'b0;
          end else begin
            init_cnt <= 1'b1;
          end
        end
        IDLE: begin
          if (arb_any) begin
            o_tx_data  <= sel_data;
            o_grant_id <= arb_idx;
            ptr        <= arb_idx;
            o_tx_start <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          o_tx_start <= 1'b0;
          wait_cnt   <= CW'(FRAME_CYCLES - 1);
          state      <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) state <= IDLE;
          else                wait_cnt <= wait_cnt - CW'(1);
        end
        default: state <= INIT;
      endcase
    end
  end

  // CYCLES_PER_SAMPLE documents the bit period the frame length is built from.
  logic unused_cps;
  assign unused_cps = (CYCLES_PER_SAMPLE == 0);

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one uart_transmitter among NUM_REQ byte requesters using round-robin arbitration.
- The transmitter has no busy or done output and re-samples i_data every cycle. This block therefore times each frame itself and holds the byte stable for the entire frame.
- Drives the transmitter's i_reset, i_data and i_start_transmission pins.
- Sits between the requesters and uart_transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLOCK_FREQUENCY, 250000000, system clock in Hz.
- BAUD_RATE, 10000, line rate in bits per second.
- CYCLES_PER_SAMPLE, CLOCK_FREQUENCY/BAUD_RATE, clock cycles per UART bit (derived).
- GUARD_CYCLES, 2, idle cycles added after each frame.
- FRAME_CYCLES, 10*CYCLES_PER_SAMPLE+2+GUARD_CYCLES, length of the WAIT window (derived).

Ports:
- clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  per-requester byte valid
- i_req_data  in  NUM_REQ*8  byte of requester k on bits [8k+7:8k]
- o_req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when valid and ready are both high
- o_tx_data  out  8  to transmitter i_data
- o_tx_start  out  1  to transmitter i_start_transmission; one-cycle pulse
- o_tx_reset  out  1  to transmitter i_reset
- o_busy  out  1  high in every state except IDLE
- o_grant_id  out  $clog2(NUM_REQ)  requester owning the current frame

Behaviour:
- Reset: clk is the only clock; i_reset_n is asynchronous and active-low. While it is asserted:
  - state=INIT, init counter=0, rr pointer=NUM_REQ-1.
  - o_tx_reset=1, o_tx_start=0, o_tx_data=0, o_busy=1, o_grant_id=0, o_req_ready=0.
- INIT: holds o_tx_reset=1 for 2 clocks after deassertion, then goes to IDLE with o_tx_reset=0. No acceptance happens in INIT.
- IDLE:
  - o_req_ready is combinational. It is one-hot on the first valid requester searched from pointer+1 modulo NUM_REQ, and 0 if no requester is valid.
  - On a transfer: register the byte into o_tx_data and the winner into o_grant_id and pointer, then go to START.
  - A requester is never accepted twice without the pointer advancing past it.
- START: o_tx_start=1 for exactly this one cycle (cycle S). Load the wait counter with FRAME_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. At 0 go to IDLE, so IDLE is at S+FRAME_CYCLES+1 and the earliest next start is S+FRAME_CYCLES+2.
  - The transmitter finishes its stop bit at S+2+10*CYCLES_PER_SAMPLE, leaving GUARD_CYCLES of margin.
- Data hold: o_tx_data is unchanged from the cycle after acceptance until re-entry to IDLE, and is not cleared afterwards.
- o_req_ready=0 in INIT, START and WAIT. Requester valid/data may change freely while it is not ready; nothing is accepted.
- Simultaneous valids: exactly one grant per frame; the others wait. Fairness bound: a continuously valid requester is served within NUM_REQ frames.
- Wait counter width: $clog2(FRAME_CYCLES+1) bits, unsigned; it never wraps.
- Reset mid-frame: asynchronous abort to INIT. o_tx_start drops immediately and o_tx_reset rises immediately. The frame is lost, not retried.

Decomposition:
- Shared package uart_pkg: TxSchedState enum {INIT, IDLE, START, WAIT}, plus a frame_cycles(clock_frequency, baud_rate, guard) function that uart_transmitter-related blocks can reuse.
- One sub-module uart_rr_arbiter: combinational rotate-priority arbiter with inputs valid[NUM_REQ] and pointer, outputs one-hot grant and grant index.

Test Plan:
All scenarios use CLOCK_FREQUENCY=100000, BAUD_RATE=10000, GUARD_CYCLES=2 (so CYCLES_PER_SAMPLE=10, FRAME_CYCLES=104), with uart_transmitter attached.
- Reset sequence: deassert i_reset_n -> o_tx_reset=1 for exactly 2 more clocks, then 0; o_req_ready=0 until IDLE.
- Single byte, req1 sends 0xA5 -> one o_tx_start pulse the cycle after the transfer.
  - o_tx line: 0 for 10 cycles, then bits 1,0,1,0,0,1,0,1 (LSB first), 10 cycles each, then 1.
  - o_busy is low again 105 cycles after the start pulse.
- All 4 requesters continuously valid with bytes 0x10..0x13 -> grant order 0,1,2,3,0.
  - Start pulses are 106 cycles apart; each frame decodes to its own byte.
- Data stability: req2 changes i_req_data every cycle after acceptance -> o_tx_data holds the accepted value for the entire frame.
- Reset mid-frame: assert i_reset_n low at start+40 -> o_tx_start=0 and o_tx_reset=1 immediately.
  - After release, o_tx stays 1 and the next request transmits cleanly.
- Pointer wrap: only req3 and then req0 valid -> req3 is granted, then req0; with both valid again, req3 is granted only after req0 has been served.
